// File: rtl/blep_pkg.sv
// Shared types, constants and helpers for the nibble-to-block memory packer.
// Also provides the word parity helper used when BLEP_PACKER_PARITY_EN is defined.
package blep_pkg;

  localparam int unsigned K_NIB_W     = 4;
  localparam int unsigned K_PAR_MAX_W = 1024;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } blep_pack_state_t;

  // Even parity of one word; callers zero-extend to K_PAR_MAX_W, which leaves the XOR unchanged.
  function automatic logic word_parity(input logic [K_PAR_MAX_W-1:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/blep_mem_packer.sv
// Packs 4-bit nibbles LSB-first into a K_DEPTH x K_DWIDTH block and holds it until the consumer takes it.
// Optional per-word parity output is enabled by defining BLEP_PACKER_PARITY_EN.
module blep_mem_packer
  import blep_pkg::*;
#(
  parameter int unsigned K_DWIDTH = 16,
  parameter int unsigned K_DEPTH  = 4
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst,
  input  logic [K_NIB_W-1:0]                        i_data,
  input  logic                                      i_data_valid,
  output logic                                      o_data_ready,
  input  logic                                      i_flush,
  output logic [K_DEPTH-1:0][K_DWIDTH-1:0]          o_mem,
  output logic                                      o_mem_valid,
  input  logic                                      i_mem_ready,
`ifdef BLEP_PACKER_PARITY_EN
  output logic [K_DEPTH-1:0]                        o_mem_parity,
`endif
  output logic [$clog2(K_DEPTH*K_DWIDTH/4+1)-1:0]   o_count
);

  localparam int unsigned NPW   = K_DWIDTH / K_NIB_W;
  localparam int unsigned TOTAL = K_DEPTH * NPW;
  localparam int unsigned CNT_W = $clog2(TOTAL + 1);
  localparam int unsigned WI_W  = $clog2(K_DEPTH);
  localparam int unsigned BO_W  = $clog2(K_DWIDTH);

  blep_pack_state_t                  state_q, state_d;
  logic [K_DEPTH-1:0][K_DWIDTH-1:0]  mem_q, mem_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic                              ready_q, ready_d;
  logic                              valid_q, valid_d;
  logic [WI_W-1:0]                   word_idx;
  logic [BO_W-1:0]                   bit_off;
  logic                              accept;

  assign accept   = i_data_valid & ready_q;
  assign word_idx = WI_W'(cnt_q / CNT_W'(NPW));
  assign bit_off  = BO_W'(K_NIB_W * (cnt_q % CNT_W'(NPW)));

  // Next-state, block write and handoff
  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          mem_d[word_idx][bit_off +: K_NIB_W] = i_data;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(TOTAL - 1) || i_flush) begin
            state_d = HOLD;
          end
        end else if (i_flush && cnt_q != '0) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (i_mem_ready) begin
          state_d = FILL;
          mem_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = FILL;
    endcase
    ready_d = (state_d == FILL);
    valid_d = (state_d == HOLD);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= FILL;
      mem_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign o_mem        = mem_q;
  assign o_count      = cnt_q;
  assign o_data_ready = ready_q;
  assign o_mem_valid  = valid_q;

`ifdef BLEP_PACKER_PARITY_EN
  logic [K_DEPTH-1:0] par_q, par_d;

  // Parity tracks the next block contents so it lines up with o_mem
  always_comb begin
    par_d = '0;
    for (int unsigned k = 0; k < K_DEPTH; k++) begin
      par_d[k] = word_parity(K_PAR_MAX_W'(mem_d[k]));
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      par_q <= '0;
    end else begin
      par_q <= par_d;
    end
  end

  assign o_mem_parity = par_q;
`endif

endmodule

// File: tb/tb_blep_mem_packer.sv
// Scoreboard bench for blep_mem_packer (K_DWIDTH=8, K_DEPTH=4): directed blocks, flushes, backpressure, reset.
// Checks parity too when BLEP_PACKER_PARITY_EN is defined.
module tb_blep_mem_packer;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic [3:0]       i_data;
  logic             i_data_valid;
  logic             o_data_ready;
  logic             i_flush;
  logic [3:0][7:0]  mem_o;
  logic             o_mem_valid;
  logic             i_mem_ready;
  logic [3:0]       o_count;
`ifdef BLEP_PACKER_PARITY_EN
  logic [3:0]       o_mem_parity;
`endif

  typedef struct {
    logic [31:0] mem;
    logic [3:0]  cnt;
    logic [3:0]  par;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  blep_mem_packer #(.K_DWIDTH(8), .K_DEPTH(4)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_data       (i_data),
    .i_data_valid (i_data_valid),
    .o_data_ready (o_data_ready),
    .i_flush      (i_flush),
    .o_mem        (mem_o),
    .o_mem_valid  (o_mem_valid),
    .i_mem_ready  (i_mem_ready),
`ifdef BLEP_PACKER_PARITY_EN
    .o_mem_parity (o_mem_parity),
`endif
    .o_count      (o_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d, input logic fl);
    i_data       = d;
    i_data_valid = 1'b1;
    i_flush      = fl;
    step();
    i_data_valid = 1'b0;
    i_flush      = 1'b0;
  endtask

  task automatic push(input logic [31:0] m, input logic [3:0] c, input logic [3:0] p);
    exp_t e;
    e.mem = m;
    e.cnt = c;
    e.par = p;
    exp_q.push_back(e);
  endtask

  // Monitor: every handshake pops one expected block
  always @(negedge i_clk) begin
    if (!i_rst && o_mem_valid && i_mem_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_block actual=%0h expected=none", 32'(mem_o));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("block_mem", 64'(mem_o), 64'(e.mem));
        chk("block_count", 64'(o_count), 64'(e.cnt));
`ifdef BLEP_PACKER_PARITY_EN
        chk("block_parity", 64'(o_mem_parity), 64'(e.par));
`endif
      end
    end
  end

  initial begin
    i_rst        = 1'b1;
    i_data       = '0;
    i_data_valid = 1'b0;
    i_flush      = 1'b0;
    i_mem_ready  = 1'b0;
    #23;
    chk("rst_valid", 64'(o_mem_valid), 64'd0);
    chk("rst_count", 64'(o_count), 64'd0);
    chk("rst_mem", 64'(mem_o), 64'd0);
    chk("rst_ready", 64'(o_data_ready), 64'd0);
    i_rst = 1'b0;
    step();
    chk("ready_after_rst", 64'(o_data_ready), 64'd1);

    // Full block 1..8, consumer always ready
    i_mem_ready = 1'b1;
    push(32'h8765_4321, 4'd8, 4'b0010);
    for (int i = 1; i <= 8; i++) send(4'(i), 1'b0);
    chk("full_latency_valid", 64'(o_mem_valid), 64'd1);
    chk("full_ready_low", 64'(o_data_ready), 64'd0);
    step();
    chk("after_hs_valid", 64'(o_mem_valid), 64'd0);
    chk("after_hs_count", 64'(o_count), 64'd0);
    chk("after_hs_mem", 64'(mem_o), 64'd0);
    chk("after_hs_ready", 64'(o_data_ready), 64'd1);

    // Partial flush on the third nibble
    push(32'h0000_0CBA, 4'd3, 4'b0001);
    send(4'hA, 1'b0);
    send(4'hB, 1'b0);
    send(4'hC, 1'b1);
    chk("partial_valid", 64'(o_mem_valid), 64'd1);
    chk("partial_count", 64'(o_count), 64'd3);
    step();

    // Backpressure: block held five cycles while upstream keeps offering data
    i_mem_ready = 1'b0;
    push(32'h89AB_CDEF, 4'd8, 4'b1111);
    for (int i = 0; i < 8; i++) send(4'(15 - i), 1'b0);
    i_data       = 4'h3;
    i_data_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_ready_low", 64'(o_data_ready), 64'd0);
      chk("bp_mem_stable", 64'(mem_o), 64'h89AB_CDEF);
      chk("bp_count_stable", 64'(o_count), 64'd8);
    end
    i_mem_ready = 1'b1;
    step();
    chk("bp_release_mem", 64'(mem_o), 64'd0);
    chk("bp_release_ready", 64'(o_data_ready), 64'd1);
    step();
    i_data_valid = 1'b0;
    chk("bp_next_count", 64'(o_count), 64'd1);
    chk("bp_next_word0", 64'(mem_o[0][3:0]), 64'h3);
    push(32'h0000_0003, 4'd1, 4'b0000);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    chk("bp_flush_valid", 64'(o_mem_valid), 64'd1);
    step();

    // Empty flush is ignored
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    chk("empty_flush_valid", 64'(o_mem_valid), 64'd0);
    chk("empty_flush_ready", 64'(o_data_ready), 64'd1);
    step();
    chk("empty_flush_valid2", 64'(o_mem_valid), 64'd0);

    // Reset while holding a block discards it asynchronously
    i_mem_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(4'(i), 1'b0);
    chk("hold_before_rst", 64'(o_mem_valid), 64'd1);
    #2;
    i_rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(o_mem_valid), 64'd0);
    chk("async_rst_mem", 64'(mem_o), 64'd0);
    chk("async_rst_count", 64'(o_count), 64'd0);
    #1;
    i_rst       = 1'b0;
    i_mem_ready = 1'b1;
    step();
    push(32'h0000_0005, 4'd1, 4'b0000);
    send(4'h5, 1'b1);
    chk("post_rst_word0", 64'(mem_o[0][3:0]), 64'h5);
    step();

    // Flush together with the last nibble is a normal full close
    push(32'h8765_4321, 4'd8, 4'b0010);
    for (int i = 1; i <= 8; i++) send(4'(i), i == 8);
    chk("flush_last_valid", 64'(o_mem_valid), 64'd1);
    chk("flush_last_count", 64'(o_count), 64'd8);
    step();
    chk("flush_last_single", 64'(o_mem_valid), 64'd0);

    step();
    step();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
